conv_loop_gen: RTL and testbench
================================

CONV_LOOP_GEN -- requirements
Module: conv_loop_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  DW, 8, counter/coordinate width
  ADDR_W, 16, address width
  IMG_H, 32, input rows
  IMG_W, 32, input columns
  IN_CH, 3, input channels
  OUT_CH, 32, output channels
  KERNEL_H, 5, kernel rows
  KERNEL_W, 5, kernel columns
  STRIDE, 1, stride (rows and columns)
  PADDING, 2, zero padding (all sides)
  OUT_H, (IMG_H+2*PADDING-KERNEL_H)/STRIDE+1, output rows
  OUT_W, (IMG_W+2*PADDING-KERNEL_W)/STRIDE+1, output columns
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk, in, 1, clock, rising edge
  reset, in, 1, asynchronous active-low reset
  start, in, 1, launch one full convolution sweep
  abort, in, 1, synchronous cancel of the sweep
  out_ready, in, 1, consumer accepts the current beat
  out_valid, out, 1, beat valid
  oc/oy/ox, out, DW each, output channel/row/column
  ky/kx/ic, out, DW each, kernel row/column, input channel
  in_row/in_col, out, DW+1 signed, input coordinate
  in_bounds, out, 1, input coordinate inside image (0 = padding, consumer uses zero)
  first, out, 1, first beat of an output pixel (clear accumulator)
  last, out, 1, last beat of an output pixel (save accumulator)
  img_addr/wgt_addr/out_addr, out, ADDR_W each, memory addresses
  busy, out, 1, sweep in progress
  done, out, 1, one-cycle end-of-sweep pulse

Function
REQ-003 FSM states: IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on acceptance of the final beat; DONE->IDLE after exactly one cycle; RUN->IDLE on abort.
REQ-004 Loop order, outermost to innermost: oc, oy, ox, ky, kx, ic; each counter wraps to 0 at its limit minus 1 and carries to the next outer counter.
REQ-005 A beat is accepted when out_valid && out_ready; counters advance only on acceptance.
REQ-006 When out_valid=1 and out_ready=0, every output SHALL hold stable.
REQ-007 out_valid SHALL be 1 in every RUN cycle and 0 in IDLE and DONE.
REQ-008 The first beat (all counters 0) SHALL be presented in the cycle after start is sampled in IDLE.
REQ-009 Every beat SHALL be emitted, padded ones included, so that total beats = OUT_CH*OUT_H*OUT_W*KERNEL_H*KERNEL_W*IN_CH.
REQ-010 in_row = STRIDE*oy + ky - PADDING and in_col = STRIDE*ox + kx - PADDING, computed signed at DW+1 bits with no wrap.
REQ-011 in_bounds = (0 <= in_row < IMG_H) && (0 <= in_col < IMG_W).
REQ-012 first = (ky==0 && kx==0 && ic==0); last = (ky==KERNEL_H-1 && kx==KERNEL_W-1 && ic==IN_CH-1).
REQ-013 img_addr = (in_row*IMG_W + in_col)*IN_CH + ic when in_bounds=1, else 0.
REQ-014 wgt_addr = ((oc*KERNEL_H + ky)*KERNEL_W + kx)*IN_CH + ic.
REQ-015 out_addr = (oc*OUT_H + oy)*OUT_W + ox.
REQ-016 Each address SHALL be truncated to ADDR_W bits.
REQ-017 All outputs SHALL be registered; coordinates, flags and addresses of a beat appear in the same cycle.
REQ-018 start SHALL be ignored in RUN and DONE.
REQ-019 busy = 1 in RUN and DONE.
REQ-020 done = 1 only in DONE.
REQ-021 abort has priority over acceptance in the same cycle: that beat is not counted, the FSM goes to IDLE, counters clear to 0, and done stays 0.
REQ-022 start and abort asserted together in IDLE: abort wins and the FSM stays in IDLE.
REQ-023 Elaboration SHALL fail if any dimension or STRIDE is 0, or if any limit exceeds 2^DW-1.

Reset
REQ-024 reset low SHALL immediately, regardless of clk, force: FSM=IDLE; all counters, in_row, in_col and addresses = 0; out_valid, first, last, in_bounds, busy, done = 0.
REQ-025 Reset asserted mid-sweep SHALL discard progress; the next start begins at oc=oy=ox=ky=kx=ic=0.
REQ-026 Release of reset SHALL be synchronised to clk by the integrator; the block takes no action until start.

Verification
REQ-027 Parameters IMG 4x4, KERNEL 3x3, PADDING=1, STRIDE=1, IN_CH=2, OUT_CH=2, out_ready tied 1, single start -> exactly 576 beats, out_valid continuous, done pulses once in the cycle after beat 576, busy falls the cycle after.
REQ-028 Same setup, first beat -> in_row=-1, in_col=-1, in_bounds=0, first=1, img_addr=0. Beat with oy=ox=1, ky=kx=1, ic=1 -> in_row=in_col=1, img_addr=11.
REQ-029 STRIDE=2, IMG 5x5, KERNEL 3x3, PADDING=0 -> OUT_H=OUT_W=2; for oc=0, oy=1, ox=1, ky=2, kx=2, ic=0: in_row=in_col=4, out_addr=3.
REQ-030 Random out_ready with 30% low -> outputs hold when stalled; the scoreboard sequence is identical to the tied-ready run; last=1 once every KERNEL_H*KERNEL_W*IN_CH beats.
REQ-031 abort after beat 100, then start -> no done pulse; the next sweep starts at all-zero counters; start pulsed during RUN has no effect.
REQ-032 reset pulled low asynchronously mid-beat -> all outputs 0 without a clock edge; after release and start, the first beat is all-zero coordinates.

Source files
------------

// File: rtl/conv_loop_gen.sv
// Convolution loop walker: steps oc/oy/ox/ky/kx/ic over a padded, strided sweep
// and presents one registered beat per coordinate, with image/weight/output addresses.
module conv_loop_gen #(
  parameter int DW       = 8,
  parameter int ADDR_W   = 16,
  parameter int IMG_H    = 32,
  parameter int IMG_W    = 32,
  parameter int IN_CH    = 3,
  parameter int OUT_CH   = 32,
  parameter int KERNEL_H = 5,
  parameter int KERNEL_W = 5,
  parameter int STRIDE   = 1,
  parameter int PADDING  = 2,
  parameter int OUT_H    = (IMG_H + 2*PADDING - KERNEL_H) / STRIDE + 1,
  parameter int OUT_W    = (IMG_W + 2*PADDING - KERNEL_W) / STRIDE + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [DW-1:0]        oc,
  output logic [DW-1:0]        oy,
  output logic [DW-1:0]        ox,
  output logic [DW-1:0]        ky,
  output logic [DW-1:0]        kx,
  output logic [DW-1:0]        ic,
  output logic signed [DW:0]   in_row,
  output logic signed [DW:0]   in_col,
  output logic                 in_bounds,
  output logic                 first,
  output logic                 last,
  output logic [ADDR_W-1:0]    img_addr,
  output logic [ADDR_W-1:0]    wgt_addr,
  output logic [ADDR_W-1:0]    out_addr,
  output logic                 busy,
  output logic                 done
);

  // state | meaning
  // IDLE  | waiting for start, all outputs cleared
  // RUN   | presenting beats, counters advance on acceptance
  // DONE  | single-cycle end-of-sweep pulse
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  localparam int LIM = (1 << DW) - 1;
  localparam int RW  = DW + 1;

  if (IMG_H < 1 || IMG_W < 1 || IN_CH < 1 || OUT_CH < 1 || KERNEL_H < 1 ||
      KERNEL_W < 1 || STRIDE < 1 || OUT_H < 1 || OUT_W < 1) begin : g_zero_dim
    $error("conv_loop_gen: every dimension and STRIDE must be non-zero");
  end
  if (IMG_H > LIM || IMG_W > LIM || IN_CH > LIM || OUT_CH > LIM || KERNEL_H > LIM ||
      KERNEL_W > LIM || STRIDE > LIM || OUT_H > LIM || OUT_W > LIM) begin : g_too_big
    $error("conv_loop_gen: a loop limit does not fit in DW bits");
  end

  localparam logic [DW-1:0] IC_LAST = DW'(IN_CH - 1);
  localparam logic [DW-1:0] KX_LAST = DW'(KERNEL_W - 1);
  localparam logic [DW-1:0] KY_LAST = DW'(KERNEL_H - 1);
  localparam logic [DW-1:0] OX_LAST = DW'(OUT_W - 1);
  localparam logic [DW-1:0] OY_LAST = DW'(OUT_H - 1);
  localparam logic [DW-1:0] OC_LAST = DW'(OUT_CH - 1);

  state_t        state_q, state_d;
  logic          valid_d, busy_d, done_d;
  logic          accept;
  logic          c_ic, c_kx, c_ky, c_ox, c_oy, c_oc;
  logic          upd, show;
  logic [DW-1:0] oc_n, oy_n, ox_n, ky_n, kx_n, ic_n;
  int            row_i, col_i;
  logic          in_bounds_n;

  assign accept = out_valid && out_ready;

  // carry chain, innermost first; c_oc marks the final beat of the sweep
  assign c_ic = (ic == IC_LAST);
  assign c_kx = c_ic && (kx == KX_LAST);
  assign c_ky = c_kx && (ky == KY_LAST);
  assign c_ox = c_ky && (ox == OX_LAST);
  assign c_oy = c_ox && (oy == OY_LAST);
  assign c_oc = c_oy && (oc == OC_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= valid_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start && !abort) state_d = S_RUN;
      S_RUN:   if (abort) state_d = S_IDLE;
               else if (accept && c_oc) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    valid_d = (state_d == S_RUN);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // upd: datapath registers load this cycle; show: the loaded beat is live (else all zero)
  always_comb begin
    upd  = 1'b0;
    show = 1'b0;
    oc_n = '0; oy_n = '0; ox_n = '0;
    ky_n = '0; kx_n = '0; ic_n = '0;
    unique case (state_q)
      S_IDLE: if (start && !abort) begin
        upd  = 1'b1;
        show = 1'b1;
      end
      S_RUN: if (abort) begin
        upd = 1'b1;
      end else if (accept) begin
        upd = 1'b1;
        if (!c_oc) begin
          show = 1'b1;
          ic_n = c_ic ? '0 : ic + 1'b1;
          kx_n = !c_ic ? kx : (c_kx ? '0 : kx + 1'b1);
          ky_n = !c_kx ? ky : (c_ky ? '0 : ky + 1'b1);
          ox_n = !c_ky ? ox : (c_ox ? '0 : ox + 1'b1);
          oy_n = !c_ox ? oy : (c_oy ? '0 : oy + 1'b1);
          oc_n = !c_oy ? oc : oc + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    row_i       = STRIDE * int'(oy_n) + int'(ky_n) - PADDING;
    col_i       = STRIDE * int'(ox_n) + int'(kx_n) - PADDING;
    in_bounds_n = show && (row_i >= 0) && (row_i < IMG_H) && (col_i >= 0) && (col_i < IMG_W);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oc        <= '0;
      oy        <= '0;
      ox        <= '0;
      ky        <= '0;
      kx        <= '0;
      ic        <= '0;
      in_row    <= '0;
      in_col    <= '0;
      in_bounds <= 1'b0;
      first     <= 1'b0;
      last      <= 1'b0;
      img_addr  <= '0;
      wgt_addr  <= '0;
      out_addr  <= '0;
    end else if (upd) begin
      oc        <= oc_n;
      oy        <= oy_n;
      ox        <= ox_n;
      ky        <= ky_n;
      kx        <= kx_n;
      ic        <= ic_n;
      in_row    <= show ? RW'(row_i) : '0;
      in_col    <= show ? RW'(col_i) : '0;
      in_bounds <= in_bounds_n;
      first     <= show && (ky_n == '0) && (kx_n == '0) && (ic_n == '0);
      last      <= show && (ky_n == KY_LAST) && (kx_n == KX_LAST) && (ic_n == IC_LAST);
      img_addr  <= in_bounds_n ? ADDR_W'((row_i * IMG_W + col_i) * IN_CH + int'(ic_n)) : '0;
      wgt_addr  <= show ? ADDR_W'(((int'(oc_n) * KERNEL_H + int'(ky_n)) * KERNEL_W
                                   + int'(kx_n)) * IN_CH + int'(ic_n)) : '0;
      out_addr  <= show ? ADDR_W'((int'(oc_n) * OUT_H + int'(oy_n)) * OUT_W + int'(ox_n)) : '0;
    end
  end

endmodule

// File: tb/tb_conv_loop_gen.sv
// Bench for conv_loop_gen: two configurations, beats scored against an index-decomposition model.
module tb_conv_loop_gen;

  typedef struct {
    int ih, iw, ich, och, kh, kw, s, p, oh, ow;
  } cfg_t;

  localparam int TOT_A = 2*4*4*3*3*2;
  localparam int TOT_B = 2*2*2*3*3*2;

  logic clk, reset;
  logic start_a, abort_a, ready_a, start_b, abort_b, ready_b;

  logic                a_valid, a_first, a_last, a_inb, a_busy, a_done;
  logic [7:0]          a_oc, a_oy, a_ox, a_ky, a_kx, a_ic;
  logic signed [8:0]   a_row, a_col;
  logic [15:0]         a_img, a_wgt, a_out;
  logic                b_valid, b_first, b_last, b_inb, b_busy, b_done;
  logic [7:0]          b_oc, b_oy, b_ox, b_ky, b_kx, b_ic;
  logic signed [8:0]   b_row, b_col;
  logic [15:0]         b_img, b_wgt, b_out;

  logic [127:0] obs_a, obs_b;
  cfg_t ca, cb;
  int n_chk = 0;
  int n_pass = 0;

  conv_loop_gen #(.DW(8), .ADDR_W(16), .IMG_H(4), .IMG_W(4), .IN_CH(2), .OUT_CH(2),
                  .KERNEL_H(3), .KERNEL_W(3), .STRIDE(1), .PADDING(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a), .out_ready(ready_a),
    .out_valid(a_valid), .oc(a_oc), .oy(a_oy), .ox(a_ox), .ky(a_ky), .kx(a_kx), .ic(a_ic),
    .in_row(a_row), .in_col(a_col), .in_bounds(a_inb), .first(a_first), .last(a_last),
    .img_addr(a_img), .wgt_addr(a_wgt), .out_addr(a_out), .busy(a_busy), .done(a_done));

  conv_loop_gen #(.DW(8), .ADDR_W(16), .IMG_H(5), .IMG_W(5), .IN_CH(2), .OUT_CH(2),
                  .KERNEL_H(3), .KERNEL_W(3), .STRIDE(2), .PADDING(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b), .out_ready(ready_b),
    .out_valid(b_valid), .oc(b_oc), .oy(b_oy), .ox(b_ox), .ky(b_ky), .kx(b_kx), .ic(b_ic),
    .in_row(b_row), .in_col(b_col), .in_bounds(b_inb), .first(b_first), .last(b_last),
    .img_addr(b_img), .wgt_addr(b_wgt), .out_addr(b_out), .busy(b_busy), .done(b_done));

  assign obs_a = {a_oc, a_oy, a_ox, a_ky, a_kx, a_ic, a_row, a_col, a_inb, a_first, a_last,
                  a_img, a_wgt, a_out, 11'd0};
  assign obs_b = {b_oc, b_oy, b_ox, b_ky, b_kx, b_ic, b_row, b_col, b_inb, b_first, b_last,
                  b_img, b_wgt, b_out, 11'd0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // beat n of the sweep, found by splitting n into mixed-radix loop digits
  function automatic logic [127:0] model(input cfg_t c, input int n);
    int ic_, kx_, ky_, ox_, oy_, oc_, r, q, img, wgt, oa;
    logic inb, f, l;
    ic_ = n % c.ich; n = n / c.ich;
    kx_ = n % c.kw;  n = n / c.kw;
    ky_ = n % c.kh;  n = n / c.kh;
    ox_ = n % c.ow;  n = n / c.ow;
    oy_ = n % c.oh;  oc_ = n / c.oh;
    r   = c.s * oy_ + ky_ - c.p;
    q   = c.s * ox_ + kx_ - c.p;
    inb = (r >= 0) && (r < c.ih) && (q >= 0) && (q < c.iw);
    img = inb ? (r * c.iw + q) * c.ich + ic_ : 0;
    wgt = ((oc_ * c.kh + ky_) * c.kw + kx_) * c.ich + ic_;
    oa  = (oc_ * c.oh + oy_) * c.ow + ox_;
    f   = (ky_ == 0) && (kx_ == 0) && (ic_ == 0);
    l   = (ky_ == c.kh - 1) && (kx_ == c.kw - 1) && (ic_ == c.ich - 1);
    return {8'(oc_), 8'(oy_), 8'(ox_), 8'(ky_), 8'(kx_), 8'(ic_), 9'(r), 9'(q), inb, f, l,
            16'(img), 16'(wgt), 16'(oa), 11'd0};
  endfunction

  task automatic sweep_a(input bit rnd, input int abort_at);
    int n = 0, cyc = 0, lasts = 0;
    bit stalled = 0, aborted = 0;
    logic [127:0] prev = '0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    while (n < TOT_A && cyc < 5000) begin
      chk("a_flags", {a_valid, a_busy, a_done}, 3'b110);
      chk("a_beat", obs_a, model(ca, n));
      if (stalled) chk("a_hold", obs_a, prev);
      if (n == 0 && !stalled) begin
        chk("first_row", a_row, -1);
        chk("first_col", a_col, -1);
        chk("first_flags", {a_inb, a_first, a_img}, {1'b0, 1'b1, 16'd0});
      end
      if (n == 99 && !stalled) begin
        chk("b99_row", a_row, 1);
        chk("b99_col", a_col, 1);
        chk("b99_img", a_img, 11);
      end
      if (n == abort_at) begin
        aborted = 1;
        abort_a = 1'b1;
        ready_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        break;
      end
      start_a = (!rnd && n == 300);
      ready_a = rnd ? ($urandom_range(0, 9) >= 3) : 1'b1;
      prev    = obs_a;
      stalled = !ready_a;
      if (ready_a) begin
        if (a_last) lasts++;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    start_a = 1'b0;
    ready_a = 1'b1;
    if (aborted) begin
      chk("abort_flags", {a_valid, a_busy, a_done}, 3'b000);
      chk("abort_clear", obs_a, '0);
      repeat (3) begin
        @(negedge clk);
        chk("abort_nodone", {a_valid, a_busy, a_done}, 3'b000);
      end
    end else begin
      chk("a_count", n, TOT_A);
      chk("a_lasts", lasts, TOT_A / 18);
      chk("a_done_pulse", {a_valid, a_busy, a_done}, 3'b011);
      @(negedge clk);
      chk("a_busy_fall", {a_valid, a_busy, a_done}, 3'b000);
    end
  endtask

  initial begin
    int n, cyc;
    ca = '{4, 4, 2, 2, 3, 3, 1, 1, 4, 4};
    cb = '{5, 5, 2, 2, 3, 3, 2, 0, 2, 2};
    reset = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; ready_a = 1'b1;
    start_b = 1'b0; abort_b = 1'b0; ready_b = 1'b1;
    @(negedge clk);
    chk("rst_flags", {a_valid, a_busy, a_done}, 3'b000);
    chk("rst_beat", obs_a, '0);
    reset = 1'b1;
    @(negedge clk);

    start_a = 1'b1; abort_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; abort_a = 1'b0;
    chk("start_abort_idle", {a_valid, a_busy, a_done}, 3'b000);

    sweep_a(1'b0, -1);
    sweep_a(1'b1, -1);
    sweep_a(1'b0, 100);

    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("restart_beat", obs_a, model(ca, 0));
    repeat (20) @(negedge clk);
    chk("midrun_beat", obs_a, model(ca, 20));
    #2 reset = 1'b0;
    #1;
    chk("async_rst_flags", {a_valid, a_busy, a_done}, 3'b000);
    chk("async_rst_beat", obs_a, '0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {a_valid, a_busy, a_done}, 3'b000);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("post_rst_beat", obs_a, model(ca, 0));
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;

    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n = 0;
    cyc = 0;
    while (n < TOT_B && cyc < 1000) begin
      chk("b_flags", {b_valid, b_busy, b_done}, 3'b110);
      chk("b_beat", obs_b, model(cb, n));
      if (n == 70) begin
        chk("b70_row", b_row, 4);
        chk("b70_col", b_col, 4);
        chk("b70_out", b_out, 3);
      end
      n++;
      cyc++;
      @(negedge clk);
    end
    chk("b_count", n, TOT_B);
    chk("b_done_pulse", {b_valid, b_busy, b_done}, 3'b011);
    @(negedge clk);
    chk("b_busy_fall", {b_valid, b_busy, b_done}, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
